// File: rtl/usb_rx_fifo.sv
// Receive byte FIFO between the USB RX decoder and the AHB slave.
// Bytes stay pending until committed; only committed bytes are visible to the slave.
module usb_rx_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6,
  parameter int unsigned CW    = 7
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          store_rx_packet_data,
  input  logic [7:0]    rx_packet_data,
  input  logic          rx_commit,
  input  logic          rx_discard,
  input  logic          get_rx_data,
  input  logic          clear,
  output logic [7:0]    rx_data,
  output logic [CW-1:0] buffer_occupancy,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rptr_q, cptr_q, wptr_q;
  logic [AW-1:0] rptr_d, cptr_d, wptr_d;
  logic [CW-1:0] ccnt_q, pcnt_q;
  logic [CW-1:0] ccnt_d, pcnt_d;
  logic          ovf_q, udf_q, ovf_d, udf_d;

  logic          full, do_store, do_pop;
  logic [AW-1:0] wptr_nx;
  logic [CW-1:0] ccnt_nx, pcnt_nx;

  // Full is judged on pre-edge counts, so a same-cycle pop never frees space.
  assign full     = (ccnt_q + pcnt_q) == DEPTH_C;
  assign do_store = store_rx_packet_data && !full;
  assign do_pop   = get_rx_data && (ccnt_q != '0);

  assign wptr_nx  = wptr_q + AW'(do_store);
  assign pcnt_nx  = pcnt_q + CW'(do_store);
  assign ccnt_nx  = ccnt_q - CW'(do_pop);

  always_comb begin
    rptr_d = rptr_q + AW'(do_pop);
    cptr_d = cptr_q;
    wptr_d = wptr_nx;
    ccnt_d = ccnt_nx;
    pcnt_d = pcnt_nx;
    ovf_d  = ovf_q || (store_rx_packet_data && full);
    udf_d  = udf_q || (get_rx_data && (ccnt_q == '0));
    if (clear) begin
      rptr_d = '0;
      cptr_d = '0;
      wptr_d = '0;
      ccnt_d = '0;
      pcnt_d = '0;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
    end else if (rx_discard) begin
      wptr_d = cptr_q;
      pcnt_d = '0;
    end else if (rx_commit) begin
      cptr_d = wptr_nx;
      ccnt_d = ccnt_nx + pcnt_nx;
      pcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rptr_q <= '0;
      cptr_q <= '0;
      wptr_q <= '0;
      ccnt_q <= '0;
      pcnt_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
      wptr_q <= wptr_d;
      ccnt_q <= ccnt_d;
      pcnt_q <= pcnt_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  // Storage is deliberately not reset; the counts gate its visibility.
  always_ff @(posedge clk) begin
    if (do_store && !clear)
      mem[wptr_q] <= rx_packet_data;
  end

  assign rx_data          = (ccnt_q == '0) ? 8'h00 : mem[rptr_q];
  assign buffer_occupancy = ccnt_q;
  assign overflow         = ovf_q;
  assign underflow        = udf_q;

endmodule

// File: tb/tb_usb_rx_fifo.sv
// Directed vector bench for usb_rx_fifo: a table of single-cycle vectors
// followed by hand-written full, wrap-around and clear sequences.
module tb_usb_rx_fifo;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       store_rx_packet_data;
  logic [7:0] rx_packet_data;
  logic       rx_commit;
  logic       rx_discard;
  logic       get_rx_data;
  logic       clear;
  logic [7:0] rx_data;
  logic [6:0] buffer_occupancy;
  logic       overflow;
  logic       underflow;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  usb_rx_fifo #(.DEPTH(64), .AW(6), .CW(7)) dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .store_rx_packet_data(store_rx_packet_data),
    .rx_packet_data      (rx_packet_data),
    .rx_commit           (rx_commit),
    .rx_discard          (rx_discard),
    .get_rx_data         (get_rx_data),
    .clear               (clear),
    .rx_data             (rx_data),
    .buffer_occupancy    (buffer_occupancy),
    .overflow            (overflow),
    .underflow           (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [7:0] d;
    logic       cm;
    logic       ds;
    logic       gt;
    logic       cl;
    int         occ;
    int         rx;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic [7:0] d, input logic cm, input logic ds,
                     input logic gt, input logic cl, input int occ, input int rx,
                     input logic ovf, input logic udf);
    vec_t v;
    v = '{st, d, cm, ds, gt, cl, occ, rx, ovf, udf};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_outs(input string name, input int occ, input int rx,
                            input logic ovf, input logic udf);
    check({name, ".occ"}, int'(buffer_occupancy), occ);
    check({name, ".rx"},  int'(rx_data), rx);
    check({name, ".ovf"}, int'(overflow), int'(ovf));
    check({name, ".udf"}, int'(underflow), int'(udf));
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic st, input logic [7:0] d, input logic cm, input logic ds,
                      input logic gt, input logic cl);
    store_rx_packet_data = st;
    rx_packet_data       = d;
    rx_commit            = cm;
    rx_discard           = ds;
    get_rx_data          = gt;
    clear                = cl;
    @(posedge clk);
    #1;
    store_rx_packet_data = 1'b0;
    rx_commit            = 1'b0;
    rx_discard           = 1'b0;
    get_rx_data          = 1'b0;
    clear                = 1'b0;
  endtask

  initial begin
    store_rx_packet_data = 1'b0;
    rx_packet_data       = 8'h00;
    rx_commit            = 1'b0;
    rx_discard           = 1'b0;
    get_rx_data          = 1'b0;
    clear                = 1'b0;
    n_rst                = 1'b0;

    //  st d      cm ds gt cl  occ rx     ovf udf
    add(0, 8'h00, 0, 0, 1, 0,  0, 8'h00, 0, 1);   // empty pop
    add(0, 8'h00, 0, 0, 0, 1,  0, 8'h00, 0, 0);   // clear flags
    add(1, 8'hA1, 0, 0, 0, 0,  0, 8'h00, 0, 0);
    add(1, 8'hA2, 0, 0, 0, 0,  0, 8'h00, 0, 0);
    add(1, 8'hA3, 0, 0, 0, 0,  0, 8'h00, 0, 0);
    add(1, 8'hA4, 1, 0, 0, 0,  4, 8'hA1, 0, 0);   // commit includes same-cycle store
    add(0, 8'h00, 0, 0, 1, 0,  3, 8'hA2, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0,  2, 8'hA3, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0,  1, 8'hA4, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0,  0, 8'h00, 0, 0);
    add(1, 8'h11, 0, 0, 0, 0,  0, 8'h00, 0, 0);
    add(1, 8'h22, 1, 0, 0, 0,  2, 8'h11, 0, 0);
    add(1, 8'h33, 0, 0, 0, 0,  2, 8'h11, 0, 0);
    add(1, 8'h44, 0, 0, 0, 0,  2, 8'h11, 0, 0);
    add(1, 8'h55, 0, 1, 0, 0,  2, 8'h11, 0, 0);   // discard drops same-cycle store
    add(1, 8'h66, 1, 0, 0, 0,  3, 8'h11, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0,  2, 8'h22, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0,  1, 8'h66, 0, 0);
    add(0, 8'h00, 0, 0, 1, 0,  0, 8'h00, 0, 0);
    add(1, 8'h99, 1, 1, 0, 0,  0, 8'h00, 0, 0);   // discard beats commit
    add(0, 8'h00, 1, 0, 0, 0,  0, 8'h00, 0, 0);
    add(1, 8'hAA, 0, 0, 0, 0,  0, 8'h00, 0, 0);
    add(0, 8'h00, 1, 0, 1, 0,  1, 8'hAA, 0, 1);   // commit does not rescue pop
    add(0, 8'h00, 0, 0, 1, 0,  0, 8'h00, 0, 1);
    add(0, 8'h00, 0, 0, 0, 1,  0, 8'h00, 0, 0);

    #3;
    check_outs("in_reset", 0, 0, 0, 0);
    #9;
    n_rst = 1'b1;
    @(posedge clk); #1;
    check_outs("after_reset", 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].st, vecs[i].d, vecs[i].cm, vecs[i].ds, vecs[i].gt, vecs[i].cl);
      check_outs($sformatf("vec%0d", i), vecs[i].occ, vecs[i].rx, vecs[i].ovf, vecs[i].udf);
    end

    // Full and overflow: 65th store alongside a pop is dropped.
    for (int i = 0; i < 64; i++) step(1, 8'(i), i == 63, 0, 0, 0);
    check_outs("full", 64, 0, 0, 0);
    step(1, 8'hEE, 0, 0, 1, 0);
    check_outs("ovf_store", 63, 1, 1, 0);
    step(0, 8'h00, 1, 0, 0, 0);
    check("ovf_commit.occ", int'(buffer_occupancy), 63);
    for (int i = 1; i < 64; i++) begin
      check($sformatf("drain%0d", i), int'(rx_data), i);
      step(0, 8'h00, 0, 0, 1, 0);
    end
    check_outs("drained", 0, 0, 1, 0);
    step(0, 8'h00, 0, 0, 0, 1);
    check_outs("clr1", 0, 0, 0, 0);

    // Wrap-around: advance all pointers to 60, then cross index 63 -> 0.
    for (int i = 0; i < 60; i++) begin
      step(1, 8'(i + 8'h40), 1, 0, 0, 0);
      step(0, 8'h00, 0, 0, 1, 0);
    end
    check_outs("stream", 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 8'(8'h80 + i), i == 9, 0, 0, 0);
    check("wrap.occ", int'(buffer_occupancy), 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("wrap%0d", i), int'(rx_data), 8'h80 + i);
      step(0, 8'h00, 0, 0, 1, 0);
    end
    check_outs("wrapped", 0, 0, 0, 0);

    // Clear mid-operation: 5 committed, 3 pending, overflow set.
    for (int i = 0; i < 64; i++) step(1, 8'(i), i == 63, 0, 0, 0);
    step(1, 8'hEE, 0, 0, 0, 0);
    check_outs("ovf_full", 64, 0, 1, 0);
    for (int i = 0; i < 59; i++) step(0, 8'h00, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i), 0, 0, 0, 0);
    check_outs("pre_clear", 5, 59, 1, 0);
    step(1, 8'hDD, 1, 0, 1, 1);
    check_outs("clear", 0, 0, 0, 0);
    step(1, 8'h77, 1, 0, 0, 0);
    check_outs("post77", 1, 8'h77, 0, 0);
    step(0, 8'h00, 0, 0, 1, 0);
    check_outs("pop77", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
